// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: per-FU result FIFOs, oldest-first registered CDB, mispredict kill; optional same-cycle bypass under WB_BYPASS_EN
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int PREG_W = 7,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [PREG_W-1:0] alu_pd,
  input  logic [31:0]       alu_data,
  input  logic [TAG_W-1:0]  alu_rob_tag,
  output logic              alu_ready,
  input  logic              b_valid,
  input  logic [PREG_W-1:0] b_pd,
  input  logic [31:0]       b_data,
  input  logic [TAG_W-1:0]  b_rob_tag,
  output logic              b_ready,
  input  logic              mem_valid,
  input  logic [PREG_W-1:0] mem_pd,
  input  logic [31:0]       mem_data,
  input  logic [TAG_W-1:0]  mem_rob_tag,
  output logic              mem_ready,
  input  logic [TAG_W-1:0]  rob_head,
  input  logic              mispredict,
  input  logic [TAG_W-1:0]  mispredict_tag,
  output logic              cdb_valid,
  output logic [PREG_W-1:0] cdb_pd,
  output logic [31:0]       cdb_data,
  output logic [TAG_W-1:0]  cdb_rob_tag
);
  localparam int NSRC    = 3;
  localparam int SRC_ALU = 0;
  localparam int SRC_B   = 1;
  localparam int SRC_MEM = 2;
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [31:0]       data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  // Entry 0 of each FIFO is always the head; a flush compacts survivors toward 0.
  entry_t           fifo_q   [NSRC][DEPTH];
  entry_t           fifo_d   [NSRC][DEPTH];
  logic [CNT_W-1:0] cnt_q    [NSRC];
  logic [CNT_W-1:0] cnt_d    [NSRC];
  entry_t           in_entry [NSRC];
  entry_t           cand     [NSRC];
  logic [NSRC-1:0]  in_valid;
  logic [NSRC-1:0]  ready;
  logic [NSRC-1:0]  cand_valid;
  logic [NSRC-1:0]  cand_bypass;
  logic [NSRC-1:0]  pop;
  logic [NSRC-1:0]  push;
  logic             win_any;
  logic [1:0]       win_src;
  entry_t           win_entry;

  // Distance from the ROB head; smaller means older.
  function automatic logic [TAG_W-1:0] age(input logic [TAG_W-1:0] t,
                                           input logic [TAG_W-1:0] head);
    return t - head;
  endfunction

  // Younger than the mispredicting branch; the branch itself survives.
  function automatic logic killed(input logic [TAG_W-1:0] t,
                                  input logic [TAG_W-1:0] head,
                                  input logic             mp,
                                  input logic [TAG_W-1:0] mp_tag);
    return mp && (age(t, head) > age(mp_tag, head));
  endfunction

  assign in_valid          = {mem_valid, b_valid, alu_valid};
  assign in_entry[SRC_ALU] = {alu_pd, alu_data, alu_rob_tag};
  assign in_entry[SRC_B]   = {b_pd, b_data, b_rob_tag};
  assign in_entry[SRC_MEM] = {mem_pd, mem_data, mem_rob_tag};

  for (genvar g = 0; g < NSRC; g++) begin : g_ready
    assign ready[g] = cnt_q[g] < FULL_CNT;
  end

  assign alu_ready = ready[SRC_ALU];
  assign b_ready   = ready[SRC_B];
  assign mem_ready = ready[SRC_MEM];

  // Per-source candidate: live FIFO head, or the incoming result when bypass is enabled and the FIFO is empty.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      cand[s]        = fifo_q[s][0];
      cand_valid[s]  = 1'b0;
      cand_bypass[s] = 1'b0;
      if (cnt_q[s] != '0) begin
        cand_valid[s] = !killed(fifo_q[s][0].tag, rob_head, mispredict, mispredict_tag);
      end
`ifdef WB_BYPASS_EN
      else if (in_valid[s]) begin
        cand[s]        = in_entry[s];
        cand_valid[s]  = !killed(in_entry[s].tag, rob_head, mispredict, mispredict_tag);
        cand_bypass[s] = 1'b1;
      end
`endif
    end
  end

  // Oldest candidate wins; scanning mem first with a strict compare gives mem > b > alu on ties.
  always_comb begin
    win_any   = 1'b0;
    win_src   = 2'(SRC_MEM);
    win_entry = cand[SRC_MEM];
    for (int s = NSRC - 1; s >= 0; s--) begin
      if (cand_valid[s] &&
          (!win_any || (age(cand[s].tag, rob_head) < age(win_entry.tag, rob_head)))) begin
        win_any   = 1'b1;
        win_src   = 2'(s);
        win_entry = cand[s];
      end
    end
  end

  // Pop the winning head; write an accepted, live result unless it already went out via bypass.
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      pop[s]  = win_any && (win_src == 2'(s)) && !cand_bypass[s];
      push[s] = in_valid[s] && ready[s] &&
                !killed(in_entry[s].tag, rob_head, mispredict, mispredict_tag) &&
                !(win_any && (win_src == 2'(s)) && cand_bypass[s]);
    end
  end

  // Rebuild each FIFO in order: drop the popped head and killed entries, then append the push.
  always_comb begin
    logic [CNT_W-1:0] wr;
    for (int s = 0; s < NSRC; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_d[s][i] = fifo_q[s][i];
      end
      wr = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CNT_W'(i) < cnt_q[s]) && !(pop[s] && (i == 0)) &&
            !killed(fifo_q[s][i].tag, rob_head, mispredict, mispredict_tag)) begin
          fifo_d[s][wr[IDX_W-1:0]] = fifo_q[s][i];
          wr = wr + 1'b1;
        end
      end
      if (push[s]) begin
        fifo_d[s][wr[IDX_W-1:0]] = in_entry[s];
        wr = wr + 1'b1;
      end
      cnt_d[s] = wr;
    end
  end

  // Occupancy counts; reset empties every FIFO at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NSRC; s++) begin
        cnt_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        cnt_q[s] <= cnt_d[s];
      end
    end
  end

  // Entry storage; contents beyond the count are don't-care, so no reset is needed.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSRC; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[s][i] <= fifo_d[s][i];
      end
    end
  end

  // Registered CDB; payload holds when no candidate wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid   <= 1'b0;
      cdb_pd      <= '0;
      cdb_data    <= '0;
      cdb_rob_tag <= '0;
    end else begin
      cdb_valid <= win_any;
      if (win_any) begin
        cdb_pd      <= win_entry.pd;
        cdb_data    <= win_entry.data;
        cdb_rob_tag <= win_entry.tag;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized self-checking bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct packed {
    logic [6:0]  pd;
    logic [31:0] data;
    logic [4:0]  tag;
  } entry_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_v [3];
  entry_t     in_e [3];
  logic [4:0] rob_head;
  logic       mispredict;
  logic [4:0] mispredict_tag;
  logic       cdb_valid;
  logic [6:0] cdb_pd;
  logic [31:0] cdb_data;
  logic [4:0] cdb_rob_tag;
  logic       alu_ready, b_ready, mem_ready;

  entry_t mq [3][$];
  logic   m_valid;
  entry_t m_cdb;
  logic   m_acc [3];
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(DEPTH), .PREG_W(7), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(in_v[0]), .alu_pd(in_e[0].pd), .alu_data(in_e[0].data),
    .alu_rob_tag(in_e[0].tag), .alu_ready(alu_ready),
    .b_valid(in_v[1]), .b_pd(in_e[1].pd), .b_data(in_e[1].data),
    .b_rob_tag(in_e[1].tag), .b_ready(b_ready),
    .mem_valid(in_v[2]), .mem_pd(in_e[2].pd), .mem_data(in_e[2].data),
    .mem_rob_tag(in_e[2].tag), .mem_ready(mem_ready),
    .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_data(cdb_data), .cdb_rob_tag(cdb_rob_tag)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int age_of(logic [4:0] t);
    return (int'(t) - int'(rob_head) + 32) % 32;
  endfunction

  function automatic bit is_killed(logic [4:0] t);
    return mispredict && (age_of(t) > age_of(mispredict_tag));
  endfunction

  function automatic logic [47:0] dut_vec();
    return {cdb_valid, cdb_pd, cdb_data, cdb_rob_tag, alu_ready, b_ready, mem_ready};
  endfunction

  function automatic logic [47:0] model_vec();
    return {m_valid, m_cdb, mq[0].size() < DEPTH, mq[1].size() < DEPTH, mq[2].size() < DEPTH};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) mq[s].delete();
    m_valid = 1'b0;
    m_cdb   = '0;
  endtask

  // One clock of the reference behaviour, evaluated on the inputs present before the edge.
  task automatic model_step();
    bit     rdy [3];
    bit     cv  [3];
    bit     byp [3];
    entry_t c   [3];
    entry_t keep [$];
    int     w;
    for (int s = 0; s < 3; s++) begin
      rdy[s] = mq[s].size() < DEPTH;
      cv[s]  = 0;
      byp[s] = 0;
      c[s]   = '0;
      if (mq[s].size() > 0) begin
        c[s]  = mq[s][0];
        cv[s] = !is_killed(c[s].tag);
      end
`ifdef WB_BYPASS_EN
      else if (in_v[s]) begin
        c[s]   = in_e[s];
        cv[s]  = !is_killed(c[s].tag);
        byp[s] = 1;
      end
`endif
    end
    w = -1;
    for (int s = 2; s >= 0; s--) begin
      if (cv[s] && (w < 0 || age_of(c[s].tag) < age_of(c[w].tag))) w = s;
    end
    for (int s = 0; s < 3; s++) begin
      if (w == s && !byp[s]) void'(mq[s].pop_front());
      keep.delete();
      foreach (mq[s][i]) if (!is_killed(mq[s][i].tag)) keep.push_back(mq[s][i]);
      mq[s] = keep;
      m_acc[s] = in_v[s] && rdy[s];
      if (m_acc[s] && !is_killed(in_e[s].tag) && !(w == s && byp[s])) mq[s].push_back(in_e[s]);
    end
    m_valid = (w >= 0);
    if (w >= 0) m_cdb = c[w];
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int s = 0; s < 3; s++) begin
      in_v[s] = 1'b0;
      in_e[s] = '0;
    end
    mispredict = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rob_head       = '0;
    mispredict_tag = '0;
    reset          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== {1'b0, 44'd0, 3'b111})
      $display("FAIL reset_state: got=%h exp=%h", dut_vec(), {1'b0, 44'd0, 3'b111});
    if (dut_vec() !== {1'b0, 44'd0, 3'b111}) errors++;
    tick();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL reset_idle: got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_single();
    rob_head = 5'd0;
    in_v[0]  = 1'b1;
    in_e[0]  = {7'd5, 32'h1234, 5'd3};
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 1) idle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL single_model: cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
      checks++;
      if (i == LAT) begin
        if ({cdb_valid, cdb_pd, cdb_data, cdb_rob_tag} !== {1'b1, 7'd5, 32'h1234, 5'd3}) begin
          errors++;
          $display("FAIL single_bcast: cyc=%0d got=%b/%0d/%h/%0d exp=1/5/1234/3",
                   i, cdb_valid, cdb_pd, cdb_data, cdb_rob_tag);
        end
      end else if (cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_idle: cyc=%0d got cdb_valid=%b exp=0", i, cdb_valid);
      end
    end
  endtask

  task automatic test_wrap_order();
    logic [4:0] seq [3];
    seq[0]   = 5'd31;
    seq[1]   = 5'd0;
    seq[2]   = 5'd2;
    rob_head = 5'd30;
    in_v[0] = 1'b1; in_e[0] = {7'd10, 32'hA0, 5'd2};
    in_v[1] = 1'b1; in_e[1] = {7'd11, 32'hB0, 5'd31};
    in_v[2] = 1'b1; in_e[2] = {7'd12, 32'hC0, 5'd0};
    for (int i = 1; i <= LAT + 3; i++) begin
      tick();
      if (i == 1) idle();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL wrap_model: cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
      checks++;
      if (i >= LAT && i < LAT + 3) begin
        if ({cdb_valid, cdb_rob_tag} !== {1'b1, seq[i-LAT]}) begin
          errors++;
          $display("FAIL wrap_order: cyc=%0d got valid=%b tag=%0d exp valid=1 tag=%0d",
                   i, cdb_valid, cdb_rob_tag, seq[i-LAT]);
        end
      end else if (cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL wrap_idle: cyc=%0d got cdb_valid=%b exp=0", i, cdb_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int         alu_sent = 0;
    int         mem_sent = 0;
    bit         full_checked = 0;
    logic [4:0] seen [$];
    bit         ok;
    rob_head = 5'd0;
    idle();
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_v[0] = (alu_sent < 8);
      in_e[0] = {7'd1, 32'(alu_sent), 5'(alu_sent)};
      in_v[2] = (mem_sent < 5);
      in_e[2] = {7'd2, 32'(100 + mem_sent), 5'(20 + mem_sent)};
      tick();
      if (m_acc[0]) alu_sent++;
      if (m_acc[2]) mem_sent++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL bp_model: cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
      if (cdb_valid === 1'b1 && cdb_pd === 7'd2) seen.push_back(cdb_rob_tag);
      if (mem_sent == 4 && alu_sent < 8 && !full_checked) begin
        full_checked = 1;
        checks++;
        if (mem_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_full: got mem_ready=%b exp=0", mem_ready);
        end
      end
    end
    idle();
    ok = (seen.size() == 5) && full_checked;
    foreach (seen[i]) if (seen[i] != 5'(20 + i)) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_sequence: got %0d mem broadcasts (full_seen=%0d) exp tags 20..24 once each",
               seen.size(), full_checked);
    end
  endtask

  task automatic test_flush();
    int n4 = 0;
    int nbad = 0;
    rob_head = 5'd0;
    idle();
    in_v[0] = 1'b1; in_e[0] = {7'd3, 32'd60, 5'd6};
    in_v[1] = 1'b1; in_e[1] = {7'd4, 32'd40, 5'd4};
    in_v[2] = 1'b1; in_e[2] = {7'd5, 32'd90, 5'd9};
    for (int i = 1; i <= 6; i++) begin
      tick();
      idle();
      if (i == 1) begin
        in_v[0]        = 1'b1;
        in_e[0]        = {7'd3, 32'd70, 5'd7};
        mispredict     = 1'b1;
        mispredict_tag = 5'd4;
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL flush_model: cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
      if (cdb_valid === 1'b1) begin
        if (cdb_rob_tag === 5'd4) n4++;
        else nbad++;
      end
    end
    checks++;
    if (n4 != 1 || nbad != 0) begin
      errors++;
      $display("FAIL flush_kill: got tag4 x%0d, other tags x%0d, exp tag4 x1, others x0", n4, nbad);
    end
    checks++;
    if (dut_vec() !== {1'b0, 7'd4, 32'd40, 5'd4, 3'b111}) begin
      errors++;
      $display("FAIL flush_end: got=%h exp=%h", dut_vec(), {1'b0, 7'd4, 32'd40, 5'd4, 3'b111});
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if ($urandom_range(0, 15) == 0) rob_head = 5'($urandom);
      mispredict     = ($urandom_range(0, 11) == 0);
      mispredict_tag = 5'($urandom);
      for (int s = 0; s < 3; s++) begin
        if (!in_v[s] && $urandom_range(0, 2) != 0) begin
          in_v[s] = 1'b1;
          in_e[s] = {7'($urandom), $urandom, 5'($urandom)};
        end
      end
      tick();
      for (int s = 0; s < 3; s++) if (m_acc[s]) in_v[s] = 1'b0;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_model: cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
    idle();
    for (int cyc = 0; cyc < 16; cyc++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random_drain: cyc=%0d got=%h exp=%h", cyc, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    rob_head = 5'd0;
    idle();
    in_v[0] = 1'b1; in_e[0] = {7'd8,  32'h11, 5'd1};
    in_v[1] = 1'b1; in_e[1] = {7'd9,  32'h22, 5'd2};
    in_v[2] = 1'b1; in_e[2] = {7'd10, 32'h33, 5'd3};
    tick();
    idle();
    in_v[0] = 1'b1; in_e[0] = {7'd11, 32'h44, 5'd4};
    tick();
    idle();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++;
      $display("FAIL rmid_pre: got=%h exp=%h", dut_vec(), model_vec());
    end
    checks++;
    if (cdb_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy: got cdb_valid=%b exp=1", cdb_valid);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== {1'b0, 44'd0, 3'b111}) begin
      errors++;
      $display("FAIL rmid_async: got=%h exp=%h", dut_vec(), {1'b0, 44'd0, 3'b111});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec() || cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_stale: cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_order();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
